// File: rtl/register_file_permute.sv
// Register file with a single write port that swaps, copies, rotates a range or writes registers.
// Optional RF_PERMUTE_CLEAR_EN adds a synchronous 'clear' input that reloads r[i]=i while idle.
module register_file_permute #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned DEPTH  = 8,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              init_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_x,
  input  logic [ADDR_W-1:0] cmd_y,
  input  logic [WIDTH-1:0]  cmd_wdata,
`ifdef RF_PERMUTE_CLEAR_EN
  input  logic              clear,
`endif
  output logic              done,
  output logic [WIDTH-1:0]  r [DEPTH-1:0]
);

  localparam logic [1:0] OP_SWAP = 2'b00;
  localparam logic [1:0] OP_COPY = 2'b01;
  localparam logic [1:0] OP_ROT  = 2'b10;

  typedef enum logic [2:0] {IDLE, SWAP_A, SWAP_B, ROT_SHIFT, ROT_LAST} state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    tmp_q, tmp_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]   lo_q, lo_d;
  logic [ADDR_W-1:0]   a_q, a_d;
  logic [ADDR_W-1:0]   b_q, b_d;
  logic                done_q, done_d;
  logic [WIDTH-1:0]    r_q [DEPTH-1:0];
  logic [WIDTH-1:0]    r_d [DEPTH-1:0];

  logic [ADDR_W-1:0]   lo_c, hi_c, ptr_m1_c;
  logic                accept_c;

`ifdef RF_PERMUTE_CLEAR_EN
  assign cmd_ready = (state_q == IDLE) && !clear;
`else
  assign cmd_ready = (state_q == IDLE);
`endif

  assign accept_c = cmd_valid && cmd_ready;
  assign lo_c     = (cmd_x < cmd_y) ? cmd_x : cmd_y;
  assign hi_c     = (cmd_x < cmd_y) ? cmd_y : cmd_x;
  assign ptr_m1_c = ptr_q - ADDR_W'(1);
  assign done     = done_q;
  assign r        = r_q;

  // Next-state and single-write-port update
  always_comb begin
    state_d = state_q;
    tmp_d   = tmp_q;
    ptr_d   = ptr_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    done_d  = 1'b0;
    r_d     = r_q;
    case (state_q)
      IDLE: begin
`ifdef RF_PERMUTE_CLEAR_EN
        if (clear) begin
          for (int unsigned i = 0; i < DEPTH; i++) r_d[i] = WIDTH'(i);
        end else
`endif
        if (accept_c) begin
          case (cmd_op)
            OP_SWAP: begin
              if (cmd_x == cmd_y) begin
                done_d = 1'b1;
              end else begin
                tmp_d   = r_q[cmd_x];
                a_d     = cmd_x;
                b_d     = cmd_y;
                state_d = SWAP_A;
              end
            end
            OP_COPY: begin
              if (cmd_x != cmd_y) r_d[cmd_y] = r_q[cmd_x];
              done_d = 1'b1;
            end
            OP_ROT: begin
              if (lo_c == hi_c) begin
                done_d = 1'b1;
              end else begin
                tmp_d   = r_q[hi_c];
                ptr_d   = hi_c;
                lo_d    = lo_c;
                state_d = ROT_SHIFT;
              end
            end
            default: begin
              r_d[cmd_x] = cmd_wdata;
              done_d     = 1'b1;
            end
          endcase
        end
      end
      SWAP_A: begin
        r_d[a_q] = r_q[b_q];
        state_d  = SWAP_B;
      end
      SWAP_B: begin
        r_d[b_q] = tmp_q;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      ROT_SHIFT: begin
        r_d[ptr_q] = r_q[ptr_m1_c];
        ptr_d      = ptr_m1_c;
        if (ptr_q == lo_q + ADDR_W'(1)) state_d = ROT_LAST;
      end
      ROT_LAST: begin
        r_d[lo_q] = tmp_q;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset loads the identity pattern
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q <= IDLE;
      tmp_q   <= '0;
      ptr_q   <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      done_q  <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) r_q[i] <= WIDTH'(i);
    end else begin
      state_q <= state_d;
      tmp_q   <= tmp_d;
      ptr_q   <= ptr_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      done_q  <= done_d;
      r_q     <= r_d;
    end
  end

endmodule

// File: tb/tb_register_file_permute.sv
// Directed bench for register_file_permute: expected register snapshots are queued per command
// and checked when done pulses. Define RF_PERMUTE_CLEAR_EN to also exercise the clear input.
module tb_register_file_permute;

  localparam int unsigned WIDTH  = 4;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned ADDR_W = 3;

  typedef logic [DEPTH-1:0][WIDTH-1:0] arr_t;

  logic              clk;
  logic              init_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_x;
  logic [ADDR_W-1:0] cmd_y;
  logic [WIDTH-1:0]  cmd_wdata;
`ifdef RF_PERMUTE_CLEAR_EN
  logic              clear;
`endif
  logic              done;
  logic [WIDTH-1:0]  r [DEPTH-1:0];

  int   tests;
  int   fails;
  arr_t m;
  arr_t sb_q[$];

  register_file_permute #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .init_n    (init_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .cmd_wdata (cmd_wdata),
`ifdef RF_PERMUTE_CLEAR_EN
    .clear     (clear),
`endif
    .done      (done),
    .r         (r)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  function automatic arr_t ident();
    arr_t a;
    for (int i = 0; i < int'(DEPTH); i++) a[i] = WIDTH'(i);
    return a;
  endfunction

  function automatic arr_t dut_r();
    arr_t a;
    for (int i = 0; i < int'(DEPTH); i++) a[i] = r[i];
    return a;
  endfunction

  // Architectural result of one command
  function automatic arr_t model(input arr_t a_in, input logic [1:0] op, input int x, input int y,
                                 input logic [WIDTH-1:0] wd);
    arr_t a;
    logic [WIDTH-1:0] t;
    int lo, hi;
    a  = a_in;
    lo = (x < y) ? x : y;
    hi = (x < y) ? y : x;
    case (op)
      2'b00: begin t = a[x]; a[x] = a[y]; a[y] = t; end
      2'b01: a[y] = a[x];
      2'b10: begin
        t = a[hi];
        for (int i = hi; i > lo; i--) a[i] = a[i-1];
        a[lo] = t;
      end
      default: a[x] = wd;
    endcase
    return a;
  endfunction

  function automatic int busy_cycles(input logic [1:0] op, input int x, input int y);
    int d;
    d = (x > y) ? x - y : y - x;
    if (op == 2'b00 && d != 0) return 2;
    if (op == 2'b10 && d != 0) return d + 1;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one command, scramble inputs while busy, then check completion
  task automatic run_cmd(input string tag, input logic [1:0] op, input int x, input int y,
                         input logic [WIDTH-1:0] wd, input logic hold_valid);
    int busy;
    bit seen;
    @(negedge clk);
    chk({tag, "_ready_pre"}, 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_x     = ADDR_W'(x);
    cmd_y     = ADDR_W'(y);
    cmd_wdata = wd;
    m = model(m, op, x, y, wd);
    sb_q.push_back(m);
    @(posedge clk);
    #1;
    cmd_valid = hold_valid;
    cmd_op    = 2'b11;
    cmd_x     = ADDR_W'($urandom_range(0, DEPTH - 1));
    cmd_y     = ADDR_W'($urandom_range(0, DEPTH - 1));
    cmd_wdata = WIDTH'($urandom);
    busy = 0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (!cmd_ready) busy++;
      if (cmd_ready) cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0;
    if (!seen) begin
      tests++;
      fails++;
      $error("FAIL %s_timeout: observed no done expected done", tag);
      void'(sb_q.pop_front());
    end else begin
      chk({tag, "_r"}, 64'(dut_r()), 64'(sb_q.pop_front()));
      chk({tag, "_busy"}, 64'(busy), 64'(busy_cycles(op, x, y)));
    end
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(done), 64'(0));
  endtask

  initial begin
    int dcount;
    tests     = 0;
    fails     = 0;
    init_n    = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_x     = '0;
    cmd_y     = '0;
    cmd_wdata = '0;
`ifdef RF_PERMUTE_CLEAR_EN
    clear     = 1'b0;
`endif

    // Reset asserted mid-cycle takes effect without a clock edge
    #15 init_n = 1'b0;
    #1;
    chk("rst_r", 64'(dut_r()), 64'(ident()));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_ready", 64'(cmd_ready), 64'(1));

    // A command offered during reset is not accepted
    cmd_valid = 1'b1;
    cmd_op    = 2'b11;
    cmd_x     = 3'd0;
    cmd_wdata = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    init_n    = 1'b1;
    m = ident();
    @(negedge clk);
    chk("rst_no_accept", 64'(dut_r()), 64'(ident()));

    run_cmd("swap07", 2'b00, 0, 7, '0, 1'b0);

    // Fresh reset then rotate with a command held pending while busy
    @(negedge clk);
    init_n = 1'b0;
    @(negedge clk);
    init_n = 1'b1;
    m = ident();
    run_cmd("rot52", 2'b10, 5, 2, '0, 1'b1);

    // WRITE then COPY back-to-back
    @(negedge clk);
    chk("b2b_ready0", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1;
    cmd_op    = 2'b11;
    cmd_x     = 3'd3;
    cmd_wdata = 4'hA;
    m = model(m, 2'b11, 3, 0, 4'hA);
    sb_q.push_back(m);
    @(negedge clk);
    chk("b2b_ready1", 64'(cmd_ready), 64'(1));
    chk("b2b_done1", 64'(done), 64'(1));
    chk("b2b_r1", 64'(dut_r()), 64'(sb_q.pop_front()));
    cmd_op = 2'b01;
    cmd_x  = 3'd3;
    cmd_y  = 3'd6;
    m = model(m, 2'b01, 3, 6, '0);
    sb_q.push_back(m);
    @(negedge clk);
    chk("b2b_ready2", 64'(cmd_ready), 64'(1));
    chk("b2b_done2", 64'(done), 64'(1));
    chk("b2b_r2", 64'(dut_r()), 64'(sb_q.pop_front()));
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("b2b_done3", 64'(done), 64'(0));

    // Degenerate and boundary operand ranges
    run_cmd("swap_same", 2'b00, 4, 4, '0, 1'b0);
    run_cmd("copy_same", 2'b01, 2, 2, '0, 1'b0);
    run_cmd("rot_same", 2'b10, 3, 3, '0, 1'b0);
    run_cmd("rot67", 2'b10, 6, 7, '0, 1'b1);
    run_cmd("rot07", 2'b10, 0, 7, '0, 1'b0);
    for (int k = 0; k < 8; k++)
      run_cmd("rand", 2'($urandom_range(0, 3)), int'($urandom_range(0, DEPTH - 1)),
              int'($urandom_range(0, DEPTH - 1)), WIDTH'($urandom), 1'($urandom_range(0, 1)));

    // Reset aborts a rotate in flight
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_x     = 3'd0;
    cmd_y     = 3'd7;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    init_n = 1'b0;
    #1;
    chk("abort_r", 64'(dut_r()), 64'(ident()));
    chk("abort_ready", 64'(cmd_ready), 64'(1));
    chk("abort_done", 64'(done), 64'(0));
    @(negedge clk);
    init_n = 1'b1;
    m = ident();
    dcount = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("abort_no_done", 64'(dcount), 64'(0));
    chk("abort_r_after", 64'(dut_r()), 64'(ident()));

`ifdef RF_PERMUTE_CLEAR_EN
    // Clear raised mid-swap waits for completion, then blocks new commands
    run_cmd("pre_clr", 2'b11, 2, 0, 4'h9, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_x     = 3'd1;
    cmd_y     = 3'd6;
    m = model(m, 2'b00, 1, 6, '0);
    sb_q.push_back(m);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    clear     = 1'b1;
    dcount = 0;
    for (int c = 0; c < 10 && dcount == 0; c++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("clr_swap_done", 64'(dcount), 64'(1));
    chk("clr_swap_r", 64'(dut_r()), 64'(sb_q.pop_front()));
    @(negedge clk);
    m = ident();
    chk("clr_r", 64'(dut_r()), 64'(ident()));
    chk("clr_no_done", 64'(done), 64'(0));
    cmd_valid = 1'b1;
    cmd_op    = 2'b11;
    cmd_x     = 3'd2;
    cmd_wdata = 4'h9;
    #1;
    chk("clr_ready", 64'(cmd_ready), 64'(0));
    repeat (2) @(negedge clk);
    chk("clr_blocked_r", 64'(dut_r()), 64'(ident()));
    chk("clr_blocked_done", 64'(done), 64'(0));
    cmd_valid = 1'b0;
    clear     = 1'b0;
    run_cmd("post_clr", 2'b00, 1, 6, '0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/register_file_permute.md
REGISTER_FILE_PERMUTE -- requirements
Module: register_file_permute

Interface
REQ-001 Parameter WIDTH, default 4, register width in bits; legal 1..32.
REQ-002 Parameter DEPTH, default 8, register count; power of two, legal 2..256.
REQ-003 Derived ADDR_W = $clog2(DEPTH); not overridable.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 init_n  in  1  asynchronous, active-low reset.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  command accepted on a rising edge when cmd_valid && cmd_ready.
REQ-008 cmd_op  in  2  00 SWAP r[x]<->r[y]; 01 COPY r[y]<=r[x]; 10 ROT rotate range up by one; 11 WRITE r[x]<=cmd_wdata.
REQ-009 cmd_x, cmd_y  in  ADDR_W each  operand indices.
REQ-010 cmd_wdata  in  WIDTH  WRITE data.
REQ-011 done  out  1  one-cycle pulse after a command completes.
REQ-012 r  out  unpacked array [DEPTH-1:0] of WIDTH bits  live register contents.

Function
REQ-013 The file SHALL write at most one register per edge (single write port); the internal temporary register tmp is WIDTH bits.
REQ-014 States SHALL be IDLE, SWAP_A, SWAP_B, ROT_SHIFT, ROT_LAST; cmd_ready = (state==IDLE), qualified per REQ-029.
REQ-015 op, x, y and wdata SHALL be captured only at acceptance; later input changes have no effect; cmd_valid while busy is ignored, not queued.
REQ-016 WRITE and COPY SHALL complete at the acceptance edge; state stays IDLE; back-to-back acceptance every cycle is legal.
REQ-017 COPY with x==y and SWAP with x==y SHALL leave r unchanged and complete at the acceptance edge.
REQ-018 SWAP x!=y: acceptance edge tmp<=r[x], go SWAP_A; next edge r[x]<=r[y], go SWAP_B; next edge r[y]<=tmp, go IDLE; 3 edges total.
REQ-019 ROT: lo=min(x,y), hi=max(x,y); result r[lo]<=old r[hi], r[i]<=old r[i-1] for lo<i<=hi; registers outside [lo,hi] unchanged.
REQ-020 ROT lo<hi: acceptance edge tmp<=r[hi], ptr<=hi, go ROT_SHIFT; each ROT_SHIFT edge r[ptr]<=r[ptr-1], ptr decrements; when ptr==lo+1 that edge goes ROT_LAST; ROT_LAST edge r[lo]<=tmp, go IDLE; hi-lo+2 edges total.
REQ-021 ROT lo==hi SHALL be a no-op completing at the acceptance edge.
REQ-022 done SHALL be registered, high exactly one cycle following each completing edge; consecutive completions give consecutive done cycles.
REQ-023 Index arithmetic SHALL be ADDR_W bits unsigned; no wrap occurs since lo<=ptr-1 always.

Reset
REQ-024 init_n low SHALL immediately, independent of clk, set r[i]=i mod 2^WIDTH, tmp=0, ptr=0, state=IDLE, done=0.
REQ-025 init_n asserted mid-SWAP or mid-ROT SHALL abort the command; partial writes are overwritten by reset values; no done is produced.
REQ-026 No command SHALL be accepted on any edge where init_n is low; first acceptance possible on first rising edge after release.

Configuration
REQ-027 Macro RF_PERMUTE_CLEAR_EN SHALL add input port clear (1 bit, after cmd_wdata).
REQ-028 With the macro, clear high on an edge in IDLE SHALL synchronously reload r[i]=i mod 2^WIDTH; done is not pulsed.
REQ-029 With the macro, cmd_ready = (state==IDLE) && !clear; clear during SWAP/ROT SHALL be held off until the command completes, then take effect on the next edge if still high.
REQ-030 Without the macro, port clear SHALL be absent and cmd_ready = (state==IDLE).

Verification (WIDTH=4, DEPTH=8)
REQ-031 init_n low at 15 ns (mid-cycle) -> r[i]=i immediately, done=0, cmd_ready=1.
REQ-032 SWAP x=0 y=7 -> after 3 edges r[0]=7, r[7]=0, others unchanged; cmd_ready low 2 cycles; done high 1 cycle.
REQ-033 ROT x=5 y=2 from reset -> after 5 edges r[2..5]=5,2,3,4; done once; cmd_ready low 4 cycles.
REQ-034 WRITE x=3 wdata=4'hA then COPY x=3 y=6 back-to-back -> r[3]=r[6]=4'hA; cmd_ready never low; done high 2 consecutive cycles.
REQ-035 ROT x=0 y=7, init_n low after 4 edges -> r[i]=i, state IDLE, no done pulse.
REQ-036 RF_PERMUTE_CLEAR_EN: clear high during SWAP x=1 y=6 -> swap completes with done, next edge r[i]=i; cmd_valid held with clear high -> not accepted.
